mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have parameter INST_MEM_WIDTH, default 2, instruction-address width of pc1 fields.
REQ-002 SHALL have parameter DATA_MEM_WIDTH, default 10, data-memory word-address width.
REQ-003 SHALL have port CLK  in  1  sole clock; all state on rising edge.
REQ-004 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports distinct, RegWrite, MemWrite, MemRead, UARTtoReg, RegtoUART  in  1 each  execute-stage control.
REQ-006 SHALL have ports MemtoReg, Branch  in  2 each  execute-stage control.
REQ-007 SHALL have ports register_data, alu_result  in  32 each  store/TX data and ALU result or address.
REQ-008 SHALL have ports rdist  in  5  and pc1  in  INST_MEM_WIDTH  destination register and return PC.
REQ-009 SHALL have ports dmem_addr  out  DATA_MEM_WIDTH, dmem_wdata  out  32, dmem_we  out  1, dmem_rdata  in  32  synchronous RAM, 1-cycle read latency.
REQ-010 SHALL have ports rx_data  in  8, rx_valid  in  1, rx_ready  out  1  UART receive FIFO pop handshake.
REQ-011 SHALL have ports tx_data  out  8, tx_valid  out  1, tx_ready  in  1  UART transmit handshake.
REQ-012 SHALL have port stall  out  1  freezes all upstream stages and their outputs.
REQ-013 SHALL have registered outputs distinct_next, RegWrite_next, MemtoReg_next[1:0], Branch_next[1:0], rdist_next[4:0], alu_result_next[31:0], uart_data[31:0], pc1_next[INST_MEM_WIDTH-1:0], and combinational output mem_data[31:0].

Function
REQ-014 SHALL run FSM with states RUN, RX_WAIT, TX_WAIT.
REQ-015 SHALL drive dmem_addr = alu_result[DATA_MEM_WIDTH-1:0] and dmem_wdata = register_data combinationally.
REQ-016 SHALL drive dmem_we = MemWrite & ~UARTtoReg & ~RegtoUART, never stalled, one write per instruction.
REQ-017 SHALL drive mem_data = dmem_rdata, aligned with control outputs registered on the same edge.
REQ-018 SHALL register all control/data inputs to *_next outputs each non-stalled cycle; latency 1 cycle.
REQ-019 UARTtoReg in RUN: rx_valid=1 -> rx_ready=1 same cycle, uart_data <= {24'b0, rx_data}, no stall; rx_valid=0 -> stall=1, go RX_WAIT.
REQ-020 RX_WAIT: stall=1, inputs held stable upstream; on rx_valid=1 assert rx_ready, capture, stall=0 that cycle, return RUN.
REQ-021 RegtoUART in RUN: tx_valid=1, tx_data = register_data[7:0]; tx_ready=1 -> complete; else stall=1, go TX_WAIT.
REQ-022 TX_WAIT: tx_valid held 1, tx_data stable; on tx_ready=1, stall=0 that cycle, return RUN.
REQ-023 While stall=1 SHALL register a bubble: RegWrite_next=0, distinct_next=0, Branch_next=2'b11; other *_next hold.
REQ-024 UARTtoReg and RegtoUART both 1: RX SHALL take priority; TX suppressed, tx_valid=0.
REQ-025 rx_ready and tx_valid SHALL be 0 outside UART instructions; rx_ready is a single-cycle pulse per byte.
REQ-026 stall SHALL be Mealy: combinational from state, UART inputs and handshakes, no added cycle.

Reset
REQ-027 reset_n=0 SHALL asynchronously force state RUN, all registered outputs 0 except Branch_next=2'b11.
REQ-028 Reset during RX_WAIT/TX_WAIT SHALL abort: stall, rx_ready, tx_valid drop to 0 immediately; no byte consumed.

Structure
REQ-029 Shared package SHALL hold the FSM state enum and MemtoReg encodings (00 ALU, 01 memory, 10 UART, 11 pc1).
REQ-030 UART RX/TX handshake FSM SHALL be one sub-module, uart_handshake; remainder is top-level pipeline registers.

Verification
REQ-031 Store: MemWrite=1, alu_result=0x10, register_data=0xDEADBEEF -> dmem_we=1, dmem_addr=0x10, stall=0, one cycle.
REQ-032 Load: MemRead=1, MemtoReg=01, RAM[0x10]=0xDEADBEEF -> next cycle mem_data=0xDEADBEEF, MemtoReg_next=01.
REQ-033 RX: UARTtoReg=1, rx_valid low 3 cycles then rx_data=0x41 -> stall 3 cycles, 3 bubbles, one rx_ready pulse, uart_data=0x00000041.
REQ-034 TX: RegtoUART=1, register_data=0x1234_5678, tx_ready low 2 cycles -> tx_valid 3 cycles, tx_data=0x78, stall 2 cycles.
REQ-035 reset_n low mid-TX_WAIT -> stall=0, tx_valid=0 without clock edge, Branch_next=2'b11, state RUN.
REQ-036 UARTtoReg=RegtoUART=MemWrite=1, rx_valid=1 -> RX completes, tx_valid=0, dmem_we=0.

Source files
------------

// File: rtl/mem_access_pkg.sv
// mem_access_pkg
// Types and constants shared by the memory-access stage and its UART
// handshake controller:
//   hs_state_e    - handshake FSM states (RUN, RX_WAIT, TX_WAIT)
//   mem_to_reg_e  - write-back source select carried on MemtoReg
//   BRANCH_BUBBLE - Branch code marking a no-op slot downstream
//   rx_extend()   - zero-extends a received UART byte to a register word
package mem_access_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_RX_WAIT = 2'b01,
    ST_TX_WAIT = 2'b10
  } hs_state_e;

  typedef enum logic [1:0] {
    MTR_ALU  = 2'b00,
    MTR_MEM  = 2'b01,
    MTR_UART = 2'b10,
    MTR_PC1  = 2'b11
  } mem_to_reg_e;

  localparam logic [1:0] BRANCH_BUBBLE = 2'b11;

  function automatic logic [31:0] rx_extend(input logic [7:0] b);
    return {24'b0, b};
  endfunction

endpackage

// File: rtl/uart_handshake.sv
// uart_handshake
// Handshake controller for UART-backed register transfers.
// Ports:
//   CLK, reset_n          - clock, asynchronous active-low reset
//   UARTtoReg, RegtoUART  - current instruction pops RX byte / pushes TX byte
//   tx_byte               - byte to transmit (low byte of store data)
//   rx_valid / rx_ready   - RX FIFO pop handshake
//   tx_data / tx_valid / tx_ready - TX handshake
//   stall                 - holds the upstream pipeline until the byte moves
// The instruction is held stable upstream while stalled, so the wait states
// only need to remember which direction is outstanding.
module uart_handshake
  import mem_access_pkg::*;
(
  input  logic       CLK,
  input  logic       reset_n,
  input  logic       UARTtoReg,
  input  logic       RegtoUART,
  input  logic [7:0] tx_byte,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       stall
);

  hs_state_e state;
  hs_state_e state_nx;
  logic      rx_req;
  logic      tx_req;
  logic      rx_op;
  logic      tx_op;

  // RX wins when an instruction asks for both directions.
  assign rx_op = UARTtoReg;
  assign tx_op = RegtoUART & ~UARTtoReg;

  always_comb begin
    state_nx = state;
    rx_req   = 1'b0;
    tx_req   = 1'b0;
    case (state)
      ST_RUN: begin
        if (rx_op) begin
          rx_req = 1'b1;
          if (!rx_valid) state_nx = ST_RX_WAIT;
        end else if (tx_op) begin
          tx_req = 1'b1;
          if (!tx_ready) state_nx = ST_TX_WAIT;
        end
      end
      ST_RX_WAIT: begin
        rx_req = 1'b1;
        if (rx_valid) state_nx = ST_RUN;
      end
      ST_TX_WAIT: begin
        tx_req = 1'b1;
        if (tx_ready) state_nx = ST_RUN;
      end
      default: state_nx = ST_RUN;
    endcase
  end

  // Mealy outputs; gated by reset_n so an abort drops them without a clock.
  assign rx_ready = reset_n & rx_req & rx_valid;
  assign tx_valid = reset_n & tx_req;
  assign stall    = reset_n & ((rx_req & ~rx_valid) | (tx_req & ~tx_ready));
  assign tx_data  = tx_byte;

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) state <= ST_RUN;
    else          state <= state_nx;
  end

endmodule

// File: rtl/mem_access.sv
// mem_access
// Memory-access pipeline stage: drives a synchronous data RAM, moves bytes
// to/from the UART, and registers the execute-stage control for write-back.
// Ports:
//   CLK, reset_n                       - clock, asynchronous active-low reset
//   distinct, RegWrite, MemWrite, MemRead, UARTtoReg, RegtoUART,
//   MemtoReg[1:0], Branch[1:0]         - execute-stage control
//   register_data, alu_result          - store/TX data, ALU result or address
//   rdist, pc1                         - destination register, return PC
//   dmem_addr/wdata/we, dmem_rdata     - data RAM (1-cycle read latency)
//   rx_data/rx_valid/rx_ready          - UART RX FIFO pop
//   tx_data/tx_valid/tx_ready          - UART TX push
//   stall                              - freezes all upstream stages
//   *_next, uart_data                  - registered write-back stage inputs
//   mem_data                           - RAM read data, aligned with *_next
module mem_access
  import mem_access_pkg::*;
#(
  parameter int INST_MEM_WIDTH = 2,
  parameter int DATA_MEM_WIDTH = 10
) (
  input  logic                      CLK,
  input  logic                      reset_n,
  input  logic                      distinct,
  input  logic                      RegWrite,
  input  logic                      MemWrite,
  input  logic                      MemRead,
  input  logic                      UARTtoReg,
  input  logic                      RegtoUART,
  input  logic [1:0]                MemtoReg,
  input  logic [1:0]                Branch,
  input  logic [31:0]               register_data,
  input  logic [31:0]               alu_result,
  input  logic [4:0]                rdist,
  input  logic [INST_MEM_WIDTH-1:0] pc1,
  output logic [DATA_MEM_WIDTH-1:0] dmem_addr,
  output logic [31:0]               dmem_wdata,
  output logic                      dmem_we,
  input  logic [31:0]               dmem_rdata,
  input  logic [7:0]                rx_data,
  input  logic                      rx_valid,
  output logic                      rx_ready,
  output logic [7:0]                tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic                      stall,
  output logic                      distinct_next,
  output logic                      RegWrite_next,
  output logic [1:0]                MemtoReg_next,
  output logic [1:0]                Branch_next,
  output logic [4:0]                rdist_next,
  output logic [31:0]               alu_result_next,
  output logic [31:0]               uart_data,
  output logic [INST_MEM_WIDTH-1:0] pc1_next,
  output logic [31:0]               mem_data
);

  // The RAM read port is always enabled, so MemRead carries no extra meaning here.
  logic unused_memread;
  assign unused_memread = MemRead;

  uart_handshake u_hs (
    .CLK       (CLK),
    .reset_n   (reset_n),
    .UARTtoReg (UARTtoReg),
    .RegtoUART (RegtoUART),
    .tx_byte   (register_data[7:0]),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .stall     (stall)
  );

  assign dmem_addr  = alu_result[DATA_MEM_WIDTH-1:0];
  assign dmem_wdata = register_data;
  // Not gated by stall: the store fires once, on the instruction's first
  // cycle, and UART instructions never write RAM.
  assign dmem_we    = MemWrite & ~UARTtoReg & ~RegtoUART;
  assign mem_data   = dmem_rdata;

  // Stage boundary: execute -> write-back
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      distinct_next   <= 1'b0;
      RegWrite_next   <= 1'b0;
      MemtoReg_next   <= 2'b00;
      Branch_next     <= BRANCH_BUBBLE;
      rdist_next      <= '0;
      alu_result_next <= '0;
      uart_data       <= '0;
      pc1_next        <= '0;
    end else begin
      if (stall) begin
        // Bubble: nothing downstream may commit or branch.
        distinct_next <= 1'b0;
        RegWrite_next <= 1'b0;
        Branch_next   <= BRANCH_BUBBLE;
      end else begin
        distinct_next   <= distinct;
        RegWrite_next   <= RegWrite;
        MemtoReg_next   <= MemtoReg;
        Branch_next     <= Branch;
        rdist_next      <= rdist;
        alu_result_next <= alu_result;
        pc1_next        <= pc1;
      end
      if (rx_ready) uart_data <= rx_extend(rx_data);
    end
  end

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;

  localparam int IW = 2;
  localparam int DW = 10;

  logic          CLK = 1'b0;
  logic          reset_n;
  logic          distinct, RegWrite, MemWrite, MemRead, UARTtoReg, RegtoUART;
  logic [1:0]    MemtoReg, Branch;
  logic [31:0]   register_data, alu_result;
  logic [4:0]    rdist;
  logic [IW-1:0] pc1;
  logic [DW-1:0] dmem_addr;
  logic [31:0]   dmem_wdata, dmem_rdata;
  logic          dmem_we;
  logic [7:0]    rx_data, tx_data;
  logic          rx_valid, rx_ready, tx_valid, tx_ready, stall;
  logic          distinct_next, RegWrite_next;
  logic [1:0]    MemtoReg_next, Branch_next;
  logic [4:0]    rdist_next;
  logic [31:0]   alu_result_next, uart_data, mem_data;
  logic [IW-1:0] pc1_next;

  mem_access #(.INST_MEM_WIDTH(IW), .DATA_MEM_WIDTH(DW)) dut (
    .CLK(CLK), .reset_n(reset_n),
    .distinct(distinct), .RegWrite(RegWrite), .MemWrite(MemWrite), .MemRead(MemRead),
    .UARTtoReg(UARTtoReg), .RegtoUART(RegtoUART), .MemtoReg(MemtoReg), .Branch(Branch),
    .register_data(register_data), .alu_result(alu_result), .rdist(rdist), .pc1(pc1),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we), .dmem_rdata(dmem_rdata),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .stall(stall),
    .distinct_next(distinct_next), .RegWrite_next(RegWrite_next), .MemtoReg_next(MemtoReg_next),
    .Branch_next(Branch_next), .rdist_next(rdist_next), .alu_result_next(alu_result_next),
    .uart_data(uart_data), .pc1_next(pc1_next), .mem_data(mem_data)
  );

  always #5 CLK = ~CLK;

  // Synchronous RAM, one-cycle read latency, read-before-write.
  logic [31:0] ram [0:1023];
  logic        ram_init;
  always @(posedge CLK) begin
    if (ram_init) begin
      for (int i = 0; i < 1024; i++) ram[i] <= '0;
      dmem_rdata <= '0;
    end else begin
      if (dmem_we) ram[dmem_addr] <= dmem_wdata;
      dmem_rdata <= ram[dmem_addr];
    end
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_instr();
    distinct = 0; RegWrite = 0; MemWrite = 0; MemRead = 0; UARTtoReg = 0; RegtoUART = 0;
    MemtoReg = 2'b00; Branch = 2'b00; register_data = '0; alu_result = '0; rdist = '0; pc1 = '0;
    rx_data = '0; rx_valid = 0; tx_ready = 0;
  endtask

  typedef struct {
    logic dis, rw, mw, mr, u2r, r2u;
    logic [1:0] m2r, br;
    logic [31:0] rdat, alu;
    logic [4:0] rd;
    logic [IW-1:0] pc;
    logic rxv;
    logic [7:0] rxd;
    logic txr;
    logic e_we, e_rxr, e_txv;
    logic [31:0] e_uart, e_mem;
  } vec_t;

  vec_t tbl [8];

  // Reference-model state for the random phase
  logic [31:0]   mm [0:1023];
  logic          m_rw, m_dis;
  logic [1:0]    m_br, m_m2r;
  logic [4:0]    m_rd;
  logic [31:0]   m_alu, m_uart;
  logic [IW-1:0] m_pc;

  initial begin
    int stall_cnt, rx_cnt, tx_cnt;
    logic hold;
    logic is_rx, is_tx, x_stall, x_rxr, x_we;
    logic [31:0] x_mem;
    int unsigned kind;

    //                dis rw mw mr u2r r2u m2r   br    rdat          alu           rd    pc   rxv rxd    txr we rxr txv uart          mem
    tbl[0] = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,32'hDEADBEEF,32'h00000010,5'd0, 2'd0,1'b0,8'h00,1'b0,1'b1,1'b0,1'b0,32'h00000000,32'h00000000};
    tbl[1] = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,2'b01,2'b00,32'h00000000,32'h00000010,5'd7, 2'd1,1'b0,8'h00,1'b0,1'b0,1'b0,1'b0,32'h00000000,32'hDEADBEEF};
    tbl[2] = '{1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,2'b10,2'b00,32'h00000000,32'h00000020,5'd3, 2'd2,1'b1,8'h5A,1'b0,1'b0,1'b1,1'b0,32'h0000005A,32'h00000000};
    tbl[3] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b10,32'hCAFE00A5,32'h00000020,5'd9, 2'd3,1'b0,8'h00,1'b1,1'b0,1'b0,1'b1,32'h0000005A,32'h00000000};
    tbl[4] = '{1'b0,1'b1,1'b1,1'b0,1'b1,1'b1,2'b10,2'b00,32'h11111111,32'h00000030,5'd4, 2'd0,1'b1,8'h33,1'b1,1'b0,1'b1,1'b0,32'h00000033,32'h00000000};
    tbl[5] = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b01,32'h0BADF00D,32'h000003FF,5'd0, 2'd0,1'b1,8'hEE,1'b1,1'b1,1'b0,1'b0,32'h00000033,32'h00000000};
    tbl[6] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,32'h00000000,32'hFFFFFFFF,5'd31,2'd3,1'b0,8'h00,1'b0,1'b0,1'b0,1'b0,32'h00000033,32'h0BADF00D};
    tbl[7] = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,2'b11,2'b10,32'h000000C3,32'h00000040,5'd1, 2'd2,1'b0,8'h00,1'b1,1'b0,1'b0,1'b1,32'h00000033,32'h00000000};

    for (int i = 0; i < 1024; i++) mm[i] = '0;

    // ---------------- reset ----------------
    clear_instr();
    reset_n  = 0;
    ram_init = 1;
    repeat (3) tick();
    chk("rst_RegWrite_next", 32'(RegWrite_next), 0);
    chk("rst_distinct_next", 32'(distinct_next), 0);
    chk("rst_Branch_next", 32'(Branch_next), 32'h3);
    chk("rst_MemtoReg_next", 32'(MemtoReg_next), 0);
    chk("rst_rdist_next", 32'(rdist_next), 0);
    chk("rst_alu_result_next", alu_result_next, 0);
    chk("rst_uart_data", uart_data, 0);
    chk("rst_pc1_next", 32'(pc1_next), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_rx_ready", 32'(rx_ready), 0);
    chk("rst_tx_valid", 32'(tx_valid), 0);
    @(negedge CLK);
    reset_n  = 1;
    ram_init = 0;
    tick();

    // ---------------- table-driven single-cycle instructions ----------------
    for (int i = 0; i < 8; i++) begin
      distinct = tbl[i].dis; RegWrite = tbl[i].rw; MemWrite = tbl[i].mw; MemRead = tbl[i].mr;
      UARTtoReg = tbl[i].u2r; RegtoUART = tbl[i].r2u; MemtoReg = tbl[i].m2r; Branch = tbl[i].br;
      register_data = tbl[i].rdat; alu_result = tbl[i].alu; rdist = tbl[i].rd; pc1 = tbl[i].pc;
      rx_valid = tbl[i].rxv; rx_data = tbl[i].rxd; tx_ready = tbl[i].txr;
      @(negedge CLK);
      chk($sformatf("v%0d_dmem_we", i), 32'(dmem_we), 32'(tbl[i].e_we));
      chk($sformatf("v%0d_dmem_addr", i), 32'(dmem_addr), 32'(tbl[i].alu[DW-1:0]));
      chk($sformatf("v%0d_dmem_wdata", i), dmem_wdata, tbl[i].rdat);
      chk($sformatf("v%0d_rx_ready", i), 32'(rx_ready), 32'(tbl[i].e_rxr));
      chk($sformatf("v%0d_tx_valid", i), 32'(tx_valid), 32'(tbl[i].e_txv));
      chk($sformatf("v%0d_stall", i), 32'(stall), 0);
      if (tbl[i].e_txv) chk($sformatf("v%0d_tx_data", i), 32'(tx_data), 32'(tbl[i].rdat[7:0]));
      tick();
      chk($sformatf("v%0d_RegWrite_next", i), 32'(RegWrite_next), 32'(tbl[i].rw));
      chk($sformatf("v%0d_distinct_next", i), 32'(distinct_next), 32'(tbl[i].dis));
      chk($sformatf("v%0d_MemtoReg_next", i), 32'(MemtoReg_next), 32'(tbl[i].m2r));
      chk($sformatf("v%0d_Branch_next", i), 32'(Branch_next), 32'(tbl[i].br));
      chk($sformatf("v%0d_rdist_next", i), 32'(rdist_next), 32'(tbl[i].rd));
      chk($sformatf("v%0d_alu_result_next", i), alu_result_next, tbl[i].alu);
      chk($sformatf("v%0d_pc1_next", i), 32'(pc1_next), 32'(tbl[i].pc));
      chk($sformatf("v%0d_uart_data", i), uart_data, tbl[i].e_uart);
      chk($sformatf("v%0d_mem_data", i), mem_data, tbl[i].e_mem);
    end

    // ---------------- RX with three empty-FIFO cycles ----------------
    clear_instr();
    RegWrite = 1; alu_result = 32'h55;
    tick();
    clear_instr();
    UARTtoReg = 1; RegWrite = 1; distinct = 1; MemtoReg = 2'b10; Branch = 2'b00;
    alu_result = 32'h77; rdist = 5'd12; rx_data = 8'h41; rx_valid = 0;
    stall_cnt = 0; rx_cnt = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      stall_cnt += int'(stall);
      rx_cnt    += int'(rx_ready);
      tick();
      chk("rx_bubble_RegWrite_next", 32'(RegWrite_next), 0);
      chk("rx_bubble_distinct_next", 32'(distinct_next), 0);
      chk("rx_bubble_Branch_next", 32'(Branch_next), 32'h3);
      chk("rx_bubble_alu_hold", alu_result_next, 32'h55);
    end
    rx_valid = 1;
    @(negedge CLK);
    chk("rx_done_stall", 32'(stall), 0);
    stall_cnt += int'(stall);
    rx_cnt    += int'(rx_ready);
    tick();
    chk("rx_uart_data", uart_data, 32'h00000041);
    chk("rx_RegWrite_next", 32'(RegWrite_next), 1);
    chk("rx_alu_result_next", alu_result_next, 32'h77);
    UARTtoReg = 0;
    @(negedge CLK);
    rx_cnt += int'(rx_ready);
    chk("rx_stall_cycles", stall_cnt, 3);
    chk("rx_ready_pulses", rx_cnt, 1);
    tick();

    // ---------------- TX with two not-ready cycles ----------------
    clear_instr();
    RegtoUART = 1; register_data = 32'h12345678; tx_ready = 0;
    stall_cnt = 0; tx_cnt = 0;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) tx_ready = 1;
      @(negedge CLK);
      stall_cnt += int'(stall);
      tx_cnt    += int'(tx_valid);
      chk("tx_data", 32'(tx_data), 32'h78);
      chk("tx_no_we", 32'(dmem_we), 0);
      tick();
    end
    chk("tx_valid_cycles", tx_cnt, 3);
    chk("tx_stall_cycles", stall_cnt, 2);
    RegtoUART = 0;
    @(negedge CLK);
    chk("tx_idle_valid", 32'(tx_valid), 0);
    tick();

    // ---------------- reset in the middle of a TX wait ----------------
    clear_instr();
    RegtoUART = 1; register_data = 32'h99; alu_result = 32'h123; RegWrite = 1; tx_ready = 0;
    tick();
    chk("txw_stall_before_reset", 32'(stall), 1);
    #2;
    reset_n = 0;
    #1;
    chk("txw_reset_stall", 32'(stall), 0);
    chk("txw_reset_tx_valid", 32'(tx_valid), 0);
    chk("txw_reset_Branch_next", 32'(Branch_next), 32'h3);
    chk("txw_reset_alu_result_next", alu_result_next, 0);
    chk("txw_reset_uart_data", uart_data, 0);
    RegtoUART = 0;
    @(negedge CLK);
    reset_n = 1;
    tick();
    chk("txw_after_reset_tx_valid", 32'(tx_valid), 0);
    chk("txw_after_reset_stall", 32'(stall), 0);

    // ---------------- randomized run against the reference model ----------------
    clear_instr();
    RegWrite = 1; distinct = 1; Branch = 2'b01; MemtoReg = 2'b11; rdist = 5'd5;
    alu_result = 32'h100; pc1 = 2'd2;
    tick();
    m_rw = 1; m_dis = 1; m_br = 2'b01; m_m2r = 2'b11; m_rd = 5'd5;
    m_alu = 32'h100; m_pc = 2'd2; m_uart = 32'h0;
    hold = 0;
    for (int c = 0; c < 400; c++) begin
      if (!hold) begin
        kind          = $urandom_range(0, 4);
        distinct      = ($urandom_range(0, 1) == 1);
        RegWrite      = ($urandom_range(0, 1) == 1);
        MemRead       = ($urandom_range(0, 1) == 1);
        MemWrite      = (kind == 1) || ($urandom_range(0, 1) == 1);
        UARTtoReg     = (kind == 2) || (kind == 4);
        RegtoUART     = (kind == 3) || (kind == 4);
        MemtoReg      = 2'($urandom());
        Branch        = 2'($urandom());
        register_data = $urandom();
        alu_result    = $urandom();
        alu_result[9:8] = 2'b01;
        rdist         = 5'($urandom());
        pc1           = IW'($urandom());
      end
      rx_valid = ($urandom_range(0, 2) != 0);
      tx_ready = ($urandom_range(0, 2) != 0);
      rx_data  = 8'($urandom());

      is_rx   = UARTtoReg;
      is_tx   = RegtoUART && !UARTtoReg;
      x_stall = (is_rx && !rx_valid) || (is_tx && !tx_ready);
      x_rxr   = is_rx && rx_valid;
      x_we    = MemWrite && !UARTtoReg && !RegtoUART;

      @(negedge CLK);
      chk("rnd_stall", 32'(stall), 32'(x_stall));
      chk("rnd_rx_ready", 32'(rx_ready), 32'(x_rxr));
      chk("rnd_tx_valid", 32'(tx_valid), 32'(is_tx));
      chk("rnd_dmem_we", 32'(dmem_we), 32'(x_we));
      if (is_tx) chk("rnd_tx_data", 32'(tx_data), 32'(register_data[7:0]));

      x_mem = mm[alu_result[9:0]];
      if (x_we) mm[alu_result[9:0]] = register_data;
      if (x_stall) begin
        m_rw = 0; m_dis = 0; m_br = 2'b11;
      end else begin
        m_rw = RegWrite; m_dis = distinct; m_br = Branch; m_m2r = MemtoReg;
        m_rd = rdist; m_alu = alu_result; m_pc = pc1;
      end
      if (x_rxr) m_uart = {24'h0, rx_data};
      hold = x_stall;

      tick();
      chk("rnd_RegWrite_next", 32'(RegWrite_next), 32'(m_rw));
      chk("rnd_distinct_next", 32'(distinct_next), 32'(m_dis));
      chk("rnd_Branch_next", 32'(Branch_next), 32'(m_br));
      chk("rnd_MemtoReg_next", 32'(MemtoReg_next), 32'(m_m2r));
      chk("rnd_rdist_next", 32'(rdist_next), 32'(m_rd));
      chk("rnd_alu_result_next", alu_result_next, m_alu);
      chk("rnd_pc1_next", 32'(pc1_next), 32'(m_pc));
      chk("rnd_uart_data", uart_data, m_uart);
      chk("rnd_mem_data", mem_data, x_mem);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
